// File: rtl/gb_cart_pkg.sv
// gb_cart_pkg: shared region constants, FSM states and MBC1 address mapping for the cartridge responder
package gb_cart_pkg;
  localparam logic [15:0] ROM0 = 16'h0000;
  localparam logic [15:0] ROMX = 16'h4000;
  localparam logic [15:0] RAM_BASE = 16'hA000;
  localparam logic [3:0] RAM_ENABLE_KEY = 4'hA;
  localparam int ROM_LO_W = 5;
  localparam int UPPER_W = 2;
  typedef enum logic [1:0] {IDLE, FETCH, DRIVE, WRITE} state_t;
  // Byte address before truncation; RAM results are already masked to ram_aw bits.
  function automatic logic [31:0] mbc1_addr(
    input logic [15:0] a,
    input logic mode,
    input logic [UPPER_W-1:0] upper,
    input logic [ROM_LO_W-1:0] rom_lo,
    input int ram_aw
  );
    logic [ROM_LO_W+UPPER_W-1:0] bank;
    bank = a[14] == ROMX[14] ? {upper, rom_lo == ROM_LO_W'(0) ? ROM_LO_W'(1) : rom_lo}
                             : (mode ? {upper, ROM_LO_W'(0)} : '0);
    return a[15] ? 32'({mode ? upper : UPPER_W'(0), a[12:0]}) & ((32'd1 << ram_aw) - 32'd1)
                 : 32'({bank, a[13:0]});
  endfunction
endpackage

// File: rtl/cart_mbc1_responder_bus_sync.sv
// bus_sync: flop chain for asynchronous bus inputs plus a two-sample stability flag
module bus_sync #(
  parameter int W = 1,
  parameter int STAGES = 2,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         stable
);
  logic [W-1:0] chain [STAGES];
  logic [W-1:0] prev;
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= INIT;
      prev <= INIT;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  assign q = chain[STAGES-1];
  assign stable = q == prev;
endmodule

// File: rtl/cart_mbc1_responder.sv
// cart_mbc1_responder: Game Boy cartridge bus responder with MBC1 mapper and req/ack backing memory
module cart_mbc1_responder
  import gb_cart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ROM_AW = 21,
  parameter int RAM_AW = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       bus_a,
  input  logic [7:0]        bus_d_in,
  input  logic              bus_rd_n,
  input  logic              bus_wr_n,
  input  logic              bus_cs_n,
  output logic [7:0]        bus_d_out,
  output logic              bus_d_oe,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_ram,
  output logic [ROM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);
  state_t state;
  logic [15:0] a_s, cur_a;
  logic [7:0] d_s;
  logic a_st, d_st, s_st, rd_n_s, wr_n_s, cs_n_s, wr_n_q, pend;
  logic ram_en, mode;
  logic [ROM_LO_W-1:0] rom_lo;
  logic [UPPER_W-1:0] upper;
  logic is_rom, is_ram, ours, wr_fall;
  logic [ROM_AW-1:0] rd_addr, wr_addr;

  bus_sync #(.W(16), .STAGES(SYNC_STAGES), .INIT(16'h0000)) u_a (
    .clk(clk), .rst(rst), .d(bus_a), .q(a_s), .stable(a_st));
  bus_sync #(.W(8), .STAGES(SYNC_STAGES), .INIT(8'h00)) u_d (
    .clk(clk), .rst(rst), .d(bus_d_in), .q(d_s), .stable(d_st));
  bus_sync #(.W(3), .STAGES(SYNC_STAGES), .INIT(3'b111)) u_s (
    .clk(clk), .rst(rst), .d({bus_rd_n, bus_wr_n, bus_cs_n}), .q({rd_n_s, wr_n_s, cs_n_s}), .stable(s_st));

  assign is_rom = a_s[15] == ROM0[15];
  assign is_ram = a_s[15:13] == RAM_BASE[15:13] && !cs_n_s;
  assign ours = is_rom || is_ram;
  assign wr_fall = !wr_n_s && wr_n_q;
  assign rd_addr = ROM_AW'(mbc1_addr(a_s, mode, upper, rom_lo, RAM_AW));
  assign wr_addr = ROM_AW'(mbc1_addr(cur_a, mode, upper, rom_lo, RAM_AW));

  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      bus_d_oe <= 1'b0;
      bus_d_out <= 8'hFF;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_ram <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      ram_en <= 1'b0;
      rom_lo <= '0;
      upper <= '0;
      mode <= 1'b0;
      cur_a <= '0;
      pend <= 1'b0;
      wr_n_q <= 1'b1;
    end else begin
      wr_n_q <= wr_n_s;
      pend <= pend | wr_fall;
      case (state)
        IDLE:
          if (a_st && (pend || wr_fall)) begin
            pend <= 1'b0;
            cur_a <= a_s;
            state <= ours ? WRITE : IDLE;
          end else if (a_st && s_st && ours && !rd_n_s && wr_n_s) begin
            cur_a <= a_s;
            mem_ram <= is_ram;
            mem_we <= 1'b0;
            mem_addr <= rd_addr;
            // Disabled SRAM answers open-bus without touching the backing memory
            if (is_ram && !ram_en) begin
              bus_d_out <= 8'hFF;
              bus_d_oe <= 1'b1;
              state <= DRIVE;
            end else begin
              mem_req <= 1'b1;
              state <= FETCH;
            end
          end
        FETCH:
          if (mem_ack) begin
            mem_req <= 1'b0;
            bus_d_out <= mem_rdata;
            bus_d_oe <= wr_n_s;
            state <= DRIVE;
          end
        DRIVE:
          if (rd_n_s || !wr_n_s || a_s != cur_a) begin
            bus_d_oe <= 1'b0;
            state <= IDLE;
          end
        WRITE:
          if (mem_req) begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              mem_we <= 1'b0;
              state <= IDLE;
            end
          end else if (wr_n_s && d_st) begin
            if (!cur_a[15]) begin
              ram_en <= cur_a[14:13] == 2'd0 ? d_s[3:0] == RAM_ENABLE_KEY : ram_en;
              rom_lo <= cur_a[14:13] == 2'd1 ? d_s[4:0] : rom_lo;
              upper <= cur_a[14:13] == 2'd2 ? d_s[1:0] : upper;
              mode <= cur_a[14:13] == 2'd3 ? d_s[0] : mode;
              state <= IDLE;
            end else if (ram_en) begin
              mem_req <= 1'b1;
              mem_we <= 1'b1;
              mem_ram <= 1'b1;
              mem_addr <= wr_addr;
              mem_wdata <= d_s;
            end else begin
              state <= IDLE;
            end
          end
      endcase
    end
endmodule

// File: tb/tb_cart_mbc1_responder.sv
// tb_cart_mbc1_responder: directed plus randomized bus traffic against a behavioural MBC1 model
module tb_cart_mbc1_responder;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] bus_a = 16'h0000;
  logic [7:0] bus_d_in = 8'h00;
  logic bus_rd_n = 1'b1, bus_wr_n = 1'b1, bus_cs_n = 1'b1;
  logic [7:0] bus_d_out;
  logic bus_d_oe, mem_req, mem_we, mem_ram;
  logic [20:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic mem_ack = 1'b0;
  int checks = 0, errors = 0;
  int cyc_cnt = 0, req_cycles = 0, wait_cnt = 0, ack_cyc = 0, oe_cyc = 0;
  logic [20:0] last_addr = '0;
  logic last_we = 1'b0, last_ram = 1'b0;
  logic [7:0] last_wdata = 8'h00;
  logic [7:0] rom_ov [int];
  logic [7:0] ram_ov [int];
  int m_ram_en = 0, m_lo = 0, m_upper = 0, m_mode = 0;

  cart_mbc1_responder dut (
    .clk(clk), .rst(rst), .bus_a(bus_a), .bus_d_in(bus_d_in), .bus_rd_n(bus_rd_n),
    .bus_wr_n(bus_wr_n), .bus_cs_n(bus_cs_n), .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ram(mem_ram), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack));

  always #10 clk = ~clk;

  function automatic logic [7:0] mem_val(input int a, input logic ram);
    if (ram) return ram_ov.exists(a) ? ram_ov[a] : 8'(a ^ (a >> 8) ^ 'h3C);
    return rom_ov.exists(a) ? rom_ov[a] : 8'(a ^ (a >> 9) ^ 'hA5);
  endfunction

  // Backing memory: acks three cycles after it first sees a request
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    mem_ack <= 1'b0;
    if (mem_req) req_cycles <= req_cycles + 1;
    if (rst || !mem_req) wait_cnt <= 0;
    else if (!mem_ack) begin
      wait_cnt <= wait_cnt + 1;
      if (wait_cnt == 2) begin
        mem_ack <= 1'b1;
        mem_rdata <= mem_val(int'(mem_addr), mem_ram);
        if (mem_we && mem_ram) ram_ov[int'(mem_addr)] = mem_wdata;
        last_addr <= mem_addr;
        last_we <= mem_we;
        last_ram <= mem_ram;
        last_wdata <= mem_wdata;
        ack_cyc <= cyc_cnt + 1;
      end
    end
  end

  function automatic int exp_addr(input int a);
    int bank;
    if (a >= 'h8000) return ((m_mode != 0 ? m_upper : 0) * 'h2000 + a % 'h2000) % 'h8000;
    bank = a < 'h4000 ? (m_mode != 0 ? m_upper * 32 : 0) : m_upper * 32 + (m_lo == 0 ? 1 : m_lo);
    return (bank * 'h4000 + a % 'h4000) % (1 << 21);
  endfunction

  task automatic model_write(input int a, input int v);
    if (a < 'h2000) m_ram_en = (v % 16 == 10) ? 1 : 0;
    else if (a < 'h4000) m_lo = v % 32;
    else if (a < 'h6000) m_upper = v % 4;
    else m_mode = v % 2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_read(input logic [15:0] addr, input logic cs, output logic got, output logic [7:0] data);
    int n;
    bus_a = addr; bus_cs_n = cs; bus_rd_n = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 40) begin cyc(1); n++; got = bus_d_oe; end
    oe_cyc = cyc_cnt;
    data = bus_d_out;
    bus_rd_n = 1'b1; bus_cs_n = 1'b1;
    cyc(8);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input logic cs);
    bus_a = addr; bus_d_in = data; bus_cs_n = cs;
    cyc(4); bus_wr_n = 1'b0;
    cyc(6); bus_wr_n = 1'b1;
    cyc(4); bus_cs_n = 1'b1;
    cyc(10);
    if (addr < 16'h8000) model_write(int'(addr), int'(data));
  endtask

  initial begin
    logic got, oe_any;
    logic [7:0] dat;
    int r0, n;
    rom_ov[32'h150] = 8'hC3;
    cyc(3);
    chk("rst_oe", bus_d_oe, 0);
    chk("rst_dout", bus_d_out, 'hFF);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    rst = 1'b0;
    cyc(4);
    // Plain ROM0 read
    do_read(16'h0150, 1'b1, got, dat);
    chk("t1_oe", got, 1);
    chk("t1_data", dat, 'hC3);
    chk("t1_addr", last_addr, 'h000150);
    chk("t1_ram", last_ram, 0);
    chk("t1_oe_lat", oe_cyc - ack_cyc, 1);
    chk("t1_oe_release", bus_d_oe, 0);
    // Bank register writes
    do_write(16'h2000, 8'h00, 1'b1);
    do_read(16'h4000, 1'b1, got, dat);
    chk("t2_bank1", last_addr, 'h004000);
    do_write(16'h2000, 8'h05, 1'b1);
    do_write(16'h4000, 8'h01, 1'b1);
    do_read(16'h7FFF, 1'b1, got, dat);
    chk("t2_bank25", last_addr, exp_addr('h7FFF));
    chk("t2_data", dat, mem_val(exp_addr('h7FFF), 1'b0));
    // SRAM disabled then enabled
    r0 = req_cycles;
    do_read(16'hA123, 1'b0, got, dat);
    chk("t3_off_oe", got, 1);
    chk("t3_off_data", dat, 'hFF);
    chk("t3_off_noreq", req_cycles - r0, 0);
    do_write(16'h0000, 8'h0A, 1'b1);
    do_write(16'hA123, 8'h5A, 1'b0);
    chk("t3_we", last_we, 1);
    chk("t3_ram", last_ram, 1);
    chk("t3_addr", last_addr, 'h0123);
    chk("t3_wdata", last_wdata, 'h5A);
    do_read(16'hA123, 1'b0, got, dat);
    chk("t3_readback", dat, 'h5A);
    // Mode 1 with upper bits, then back to mode 0
    do_write(16'h6000, 8'h01, 1'b1);
    do_write(16'h4000, 8'h02, 1'b1);
    do_read(16'h0000, 1'b1, got, dat);
    chk("t4_m1_rom", last_addr, 'h100000);
    do_read(16'hB000, 1'b0, got, dat);
    chk("t4_m1_ram", last_addr, 'h5000);
    do_write(16'h6000, 8'h00, 1'b1);
    do_read(16'h0000, 1'b1, got, dat);
    chk("t4_m0_rom", last_addr, 'h000000);
    do_read(16'hB000, 1'b0, got, dat);
    chk("t4_m0_ram", last_addr, 'h1000);
    // Reset in the middle of a fetch
    bus_a = 16'h0150; bus_rd_n = 1'b0; n = 0;
    while (!mem_req && n < 20) begin cyc(1); n++; end
    chk("t5_req_seen", mem_req, 1);
    bus_rd_n = 1'b1; rst = 1'b1;
    cyc(1);
    chk("t5_req_drop", mem_req, 0);
    chk("t5_oe_drop", bus_d_oe, 0);
    rst = 1'b0;
    m_ram_en = 0; m_lo = 0; m_upper = 0; m_mode = 0;
    cyc(4);
    do_read(16'h4000, 1'b1, got, dat);
    chk("t5_lo_upper_reset", last_addr, 'h004000);
    do_read(16'h0000, 1'b1, got, dat);
    chk("t5_mode_reset", last_addr, 'h000000);
    r0 = req_cycles;
    do_read(16'hA000, 1'b0, got, dat);
    chk("t5_ram_en_reset", dat, 'hFF);
    chk("t5_ram_en_noreq", req_cycles - r0, 0);
    // Addresses that are not ours, and a one-sample glitch
    r0 = req_cycles;
    do_read(16'hC000, 1'b0, got, dat);
    chk("t6_c000_oe", got, 0);
    do_read(16'hA000, 1'b1, got, dat);
    chk("t6_cs_high_oe", got, 0);
    bus_a = 16'hC000; bus_rd_n = 1'b0;
    cyc(6);
    bus_a = 16'h0150;
    cyc(1);
    bus_a = 16'hC000; oe_any = 1'b0;
    repeat (12) begin cyc(1); oe_any |= bus_d_oe; end
    bus_rd_n = 1'b1;
    cyc(4);
    chk("t6_glitch_oe", oe_any, 0);
    chk("t6_noreq", req_cycles - r0, 0);
    // rd and wr low together: the write is taken, nothing is driven
    do_write(16'h0000, 8'h0A, 1'b1);
    r0 = req_cycles;
    bus_a = 16'h0150; bus_d_in = 8'h00; bus_rd_n = 1'b0; bus_wr_n = 1'b0; oe_any = 1'b0;
    repeat (10) begin cyc(1); oe_any |= bus_d_oe; end
    bus_rd_n = 1'b1; bus_wr_n = 1'b1;
    repeat (10) begin cyc(1); oe_any |= bus_d_oe; end
    model_write('h150, 0);
    chk("t7_both_oe", oe_any, 0);
    chk("t7_both_noreq", req_cycles - r0, 0);
    do_read(16'hA000, 1'b0, got, dat);
    chk("t7_ram_disabled", dat, 'hFF);
    // Randomized mapper traffic against the reference model
    for (int i = 0; i < 18; i++) begin
      int kind, a, v;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        a = $urandom_range(0, 3) * 'h2000 + $urandom_range(0, 'h1FFF);
        v = ($urandom_range(0, 1) == 1 && a < 'h2000) ? 'h0A : $urandom_range(0, 255);
        do_write(16'(a), 8'(v), 1'b1);
      end else begin
        a = kind == 1 ? $urandom_range(0, 'h7FFF) : $urandom_range('hA000, 'hBFFF);
        r0 = req_cycles;
        do_read(16'(a), 1'b0, got, dat);
        chk("rnd_oe", got, 1);
        if (kind == 2 && m_ram_en == 0) begin
          chk("rnd_ram_off_data", dat, 'hFF);
          chk("rnd_ram_off_noreq", req_cycles - r0, 0);
        end else begin
          chk("rnd_addr", last_addr, exp_addr(a));
          chk("rnd_data", dat, mem_val(exp_addr(a), kind == 2));
        end
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
